// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 UART receiver with 16x oversampling. The incoming line is
//            synchronised, the start bit is qualified at its midpoint, and
//            data/stop bits are sampled at their centres. One byte is held
//            in rx_data with an availability flag and sticky error flags.
// Ports    : clk        - system clock, rising edge
//            rst        - synchronous active-high reset
//            uart_rxd   - asynchronous serial input, idle high
//            rx_data    - last correctly framed byte
//            rx_avail   - unacknowledged byte present in rx_data
//            rx_error   - framing error (stop bit low), sticky
//            rx_overrun - byte completed while rx_avail was high, sticky
//            rx_ack     - one-cycle pulse: consume byte, clear flags
//            rx_busy    - receiver is inside a frame
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int clk_freq  = 100000000,
  parameter int baud_rate = 1152000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rxd,
  output logic [7:0] rx_data,
  output logic       rx_avail,
  output logic       rx_error,
  output logic       rx_overrun,
  input  logic       rx_ack,
  output logic       rx_busy
);

  localparam int c_div_raw = clk_freq / (baud_rate * 16);
  localparam int c_divisor = (c_div_raw < 1) ? 1 : c_div_raw;
  localparam int c_tick_w  = (c_divisor > 1) ? $clog2(c_divisor) : 1;
  localparam logic [c_tick_w-1:0] c_tick_max = c_tick_w'(c_divisor - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]          state_q,    state_d;
  logic                sync1_q,    sync1_d;
  logic                sync2_q,    sync2_d;
  logic [c_tick_w-1:0] tick_cnt_q, tick_cnt_d;
  logic [3:0]          os_cnt_q,   os_cnt_d;
  logic [2:0]          bit_cnt_q,  bit_cnt_d;
  logic [7:0]          shift_q,    shift_d;
  logic [7:0]          data_q,     data_d;
  logic                avail_q,    avail_d;
  logic                error_q,    error_d;
  logic                overrun_q,  overrun_d;
  logic                armed_q,    armed_d;

  logic rxs;
  logic tick;
  logic start_smp;
  logic data_smp;
  logic stop_smp;

  assign rxs  = sync2_q;
  assign tick = (state_q != S_IDLE) && (tick_cnt_q == c_tick_max);

  // Sample strobes: mid start bit after 8 ticks, data/stop every 16 ticks.
  assign start_smp = (state_q == S_START) && tick && (os_cnt_q == 4'd7);
  assign data_smp  = (state_q == S_DATA)  && tick && (os_cnt_q == 4'd15);
  assign stop_smp  = (state_q == S_STOP)  && tick && (os_cnt_q == 4'd15);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      // armed_q blocks a restart on a line still low after a framing error
      S_IDLE:  if (armed_q && !rxs) state_d = S_START;
      S_START: if (start_smp) state_d = rxs ? S_IDLE : S_DATA;
      S_DATA:  if (data_smp && (bit_cnt_q == 3'd7)) state_d = S_STOP;
      S_STOP:  if (stop_smp) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    rx_busy = (state_q != S_IDLE);
  end

  // --------------------------------------------------------------------------
  // Datapath next-state
  // --------------------------------------------------------------------------
  always_comb begin
    sync1_d    = uart_rxd;
    sync2_d    = sync1_q;
    tick_cnt_d = tick_cnt_q;
    os_cnt_d   = os_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    avail_d    = avail_q;
    error_d    = error_q;
    overrun_d  = overrun_q;
    armed_d    = rxs ? 1'b1 : armed_q;

    if (state_q == S_IDLE) begin
      tick_cnt_d = '0;
      os_cnt_d   = 4'd0;
    end else begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + c_tick_w'(1);
      if (tick) os_cnt_d = os_cnt_q + 4'd1;
    end

    // Entering DATA re-aligns the oversample phase to the start-bit centre
    if (start_smp) begin
      os_cnt_d  = 4'd0;
      bit_cnt_d = 3'd0;
    end

    if (data_smp) begin
      shift_d   = {rxs, shift_q[7:1]};
      bit_cnt_d = bit_cnt_q + 3'd1;
    end

    if (rx_ack) begin
      avail_d   = 1'b0;
      error_d   = 1'b0;
      overrun_d = 1'b0;
    end

    // A completion in the same cycle as rx_ack takes priority over the ack
    if (stop_smp) begin
      if (rxs) begin
        data_d  = shift_q;
        avail_d = 1'b1;
        if (avail_q && !rx_ack) overrun_d = 1'b1;
      end else begin
        error_d = 1'b1;
        armed_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      tick_cnt_q <= '0;
      os_cnt_q   <= 4'd0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      data_q     <= 8'h00;
      avail_q    <= 1'b0;
      error_q    <= 1'b0;
      overrun_q  <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      tick_cnt_q <= tick_cnt_d;
      os_cnt_q   <= os_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      avail_q    <= avail_d;
      error_q    <= error_d;
      overrun_q  <= overrun_d;
      armed_q    <= armed_d;
    end
  end

  assign rx_data    = data_q;
  assign rx_avail   = avail_q;
  assign rx_error   = error_q;
  assign rx_overrun = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Self-checking bench for uart_rx. Frames are driven at the pin
//            level; a frame-level model predicts the held byte and flags,
//            and a compare process checks them every idle cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int CLK_FREQ  = 100000000;
  localparam int BAUD_RATE = 625000;
  localparam int BIT_CLKS  = CLK_FREQ / BAUD_RATE;            // 160
  localparam int DIVISOR   = CLK_FREQ / (BAUD_RATE * 16);     // 10
  localparam int LAT_NOM   = 2 + (8 + 8 * 16 + 16) * DIVISOR; // 1522

  logic       clk;
  logic       rst;
  logic       uart_rxd;
  logic [7:0] rx_data;
  logic       rx_avail;
  logic       rx_error;
  logic       rx_overrun;
  logic       rx_ack;
  logic       rx_busy;

  uart_rx #(
    .clk_freq  (CLK_FREQ),
    .baud_rate (BAUD_RATE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .uart_rxd   (uart_rxd),
    .rx_data    (rx_data),
    .rx_avail   (rx_avail),
    .rx_error   (rx_error),
    .rx_overrun (rx_overrun),
    .rx_ack     (rx_ack),
    .rx_busy    (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Frame-level model of the receiver's visible state
  logic [7:0] m_data;
  logic       m_avail;
  logic       m_error;
  logic       m_overrun;
  logic       chk_en;
  int         lat_meas;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every idle cycle the outputs must match the model and the receiver must be idle
  always @(negedge clk) begin
    if (chk_en) begin
      check("idle_outputs",
            {19'd0, rx_data, rx_avail, rx_error, rx_overrun, rx_busy},
            {19'd0, m_data, m_avail, m_error, m_overrun, 1'b0});
    end
  end

  task automatic model_reset();
    m_data = 8'h00; m_avail = 1'b0; m_error = 1'b0; m_overrun = 1'b0;
  endtask

  // Effect of one completed frame; ack_same says rx_ack hit the completion cycle
  task automatic model_frame(input logic [7:0] b, input bit stop, input bit ack_same);
    if (ack_same) begin
      m_avail = 1'b0; m_error = 1'b0; m_overrun = 1'b0;
    end
    if (stop) begin
      if (m_avail) m_overrun = 1'b1;
      m_data  = b;
      m_avail = 1'b1;
    end else begin
      m_error = 1'b1;
    end
  endtask

  // Pin-level 8N1 frame; the line is left at the stop-bit level
  task automatic send_frame(input logic [7:0] b, input bit stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      uart_rxd = bits[i];
      repeat (BIT_CLKS - 1) @(negedge clk);
    end
  endtask

  task automatic do_ack();
    @(negedge clk);
    rx_ack = 1'b1;
    @(posedge clk);
    #1;
    m_avail = 1'b0; m_error = 1'b0; m_overrun = 1'b0;
    check("ack_clears_avail", {31'd0, rx_avail}, 32'd0);
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; uart_rxd = 1'b1; rx_ack = 1'b0; chk_en = 1'b0;
    lat_meas = LAT_NOM + 1;
    model_reset();

    // Reset state
    repeat (4) @(posedge clk);
    #1;
    check("reset_outputs", {20'd0, rx_data, rx_avail, rx_error, rx_overrun, rx_busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(20);
    chk_en = 1'b1;

    // 0xA5, good stop, with latency measurement
    chk_en = 1'b0;
    fork
      send_frame(8'hA5, 1'b1);
      begin : lat_meas_blk
        int  n;
        bit  seen;
        n = 0; seen = 1'b0;
        @(negedge clk);
        while (!seen && n < 3000) begin
          @(posedge clk);
          n++;
          #1;
          if (rx_avail) seen = 1'b1;
        end
        n_checks++;
        if (!seen || n < LAT_NOM - 1 || n > LAT_NOM + 5) begin
          n_err++;
          $display("FAIL latency: got %0d cycles (seen=%0d), expected %0d..%0d",
                   n, seen, LAT_NOM - 1, LAT_NOM + 5);
        end
        if (seen) lat_meas = n;
      end
    join
    model_frame(8'hA5, 1'b1, 1'b0);
    chk_en = 1'b1;
    check("a5_data", {24'd0, rx_data}, 32'h0000_00A5);
    check("a5_avail", {31'd0, rx_avail}, 32'd1);
    idle(5);
    do_ack();
    idle(5);

    // 0x3C with a low stop bit, line kept low afterwards
    chk_en = 1'b0;
    send_frame(8'h3C, 1'b0);
    model_frame(8'h3C, 1'b0, 1'b0);
    chk_en = 1'b1;
    check("ferr_error", {31'd0, rx_error}, 32'd1);
    check("ferr_data_kept", {24'd0, rx_data}, 32'h0000_00A5);
    check("ferr_avail", {31'd0, rx_avail}, 32'd0);
    idle(400);
    check("ferr_no_restart", {31'd0, rx_busy}, 32'd0);
    uart_rxd = 1'b1;
    idle(50);
    do_ack();
    idle(10);

    // 40-clock glitch on an idle line
    chk_en = 1'b0;
    @(negedge clk);
    uart_rxd = 1'b0;
    idle(20);
    check("glitch_busy", {31'd0, rx_busy}, 32'd1);
    idle(20);
    uart_rxd = 1'b1;
    idle(140);
    chk_en = 1'b1;
    check("glitch_flags", {30'd0, rx_avail, rx_error}, 32'd0);

    // Overrun: 0x11 then 0x22 without ack
    chk_en = 1'b0;
    send_frame(8'h11, 1'b1);
    model_frame(8'h11, 1'b1, 1'b0);
    idle(10);
    send_frame(8'h22, 1'b1);
    model_frame(8'h22, 1'b1, 1'b0);
    chk_en = 1'b1;
    check("ovr_data", {24'd0, rx_data}, 32'h0000_0022);
    check("ovr_flags", {30'd0, rx_avail, rx_overrun}, 32'd3);
    idle(5);
    do_ack();
    check("ovr_cleared", {31'd0, rx_overrun}, 32'd0);
    idle(5);

    // Reset halfway through the data bits of 0xFF
    chk_en = 1'b0;
    fork
      send_frame(8'hFF, 1'b1);
      begin
        idle(800);
        check("mid_frame_busy", {31'd0, rx_busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_outputs", {20'd0, rx_data, rx_avail, rx_error, rx_overrun, rx_busy}, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
      end
    join
    chk_en = 1'b1;
    idle(20);
    chk_en = 1'b0;
    send_frame(8'h5A, 1'b1);
    model_frame(8'h5A, 1'b1, 1'b0);
    chk_en = 1'b1;
    check("after_rst_data", {24'd0, rx_data}, 32'h0000_005A);
    idle(10);

    // rx_ack exactly on the completion cycle of 0x77 (rx_avail already high)
    chk_en = 1'b0;
    fork
      send_frame(8'h77, 1'b1);
      begin
        @(negedge clk);
        repeat (lat_meas - 1) @(negedge clk);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
      end
    join
    model_frame(8'h77, 1'b1, 1'b1);
    chk_en = 1'b1;
    check("ackcol_data", {24'd0, rx_data}, 32'h0000_0077);
    check("ackcol_flags", {30'd0, rx_avail, rx_overrun}, 32'd2);
    idle(10);

    // Randomised frames
    for (int k = 0; k < 12; k++) begin
      logic [7:0] b;
      bit         stop;
      b    = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      idle($urandom_range(5, 50));
      if ($urandom_range(0, 2) == 0) do_ack();
      chk_en = 1'b0;
      send_frame(b, stop);
      model_frame(b, stop, 1'b0);
      chk_en = 1'b1;
      if (!stop) begin
        idle($urandom_range(20, 300));
        uart_rxd = 1'b1;
      end
      idle(30);
    end

    chk_en = 1'b0;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
Parameters:
REQ-001 SHALL have parameter clk_freq, default 100000000: system clock frequency in Hz.
REQ-002 SHALL have parameter baud_rate, default 1152000: serial bit rate in bit/s.
Ports:
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port uart_rxd  input  1  asynchronous serial line; idle high.
REQ-006 SHALL have port rx_data  output  8  last correctly framed byte received.
REQ-007 SHALL have port rx_avail  output  1  high while an unacknowledged byte is held in rx_data.
REQ-008 SHALL have port rx_error  output  1  framing error seen (stop bit sampled 0); sticky until acknowledged.
REQ-009 SHALL have port rx_overrun  output  1  a byte completed while rx_avail was high; sticky until acknowledged.
REQ-010 SHALL have port rx_ack  input  1  single-cycle pulse that consumes the held byte and clears the flags.
REQ-011 SHALL have port rx_busy  output  1  high in every state except IDLE.

Function
REQ-012 SHALL pass uart_rxd through a 2-flop synchronizer; all decisions use the synchronized value (rxs).
REQ-013 SHALL derive divisor = clk_freq / (baud_rate*16), integer-truncated, minimum 1; the tick counter counts 0..divisor-1 and asserts a 1-cycle tick at divisor-1.
REQ-014 SHALL hold the tick counter and the 4-bit oversample counter at 0 in IDLE; both start counting on the cycle after IDLE is left.
REQ-015 SHALL implement the state machine IDLE, START, DATA, STOP (2-bit encoding).
REQ-016 IDLE -> START when rxs=0.
REQ-017 START: after 8 ticks (mid start bit), sample rxs; if 0 -> DATA with oversample and bit counters cleared; if 1 -> IDLE (glitch, no flag set).
REQ-018 DATA: every 16 ticks, sample rxs into a shift register, LSB first; after the 8th sample -> STOP.
REQ-019 STOP: after 16 ticks, sample rxs; if 1 -> load rx_data from the shift register and set rx_avail; if 0 -> set rx_error and leave rx_data unchanged; in both cases -> IDLE in the same cycle.
REQ-020 On a good stop bit with rx_avail already high and no rx_ack in that cycle, SHALL overwrite rx_data and set rx_overrun.
REQ-021 rx_ack SHALL clear rx_avail, rx_error and rx_overrun on the next edge.
REQ-022 If rx_ack coincides with a completion, the completion SHALL win: rx_avail=1 with the new byte, rx_overrun not set, and rx_error set if the stop bit was 0.
REQ-023 rx_ack while rx_avail=0 SHALL have no effect other than clearing the flags.
REQ-024 After a framing error, SHALL not accept a new start until rxs has returned to 1 (IDLE requires a high line before REQ-016 can fire).
REQ-025 Nominal latency: rx_avail rises 2 sync cycles + (8+8*16+16)*divisor cycles (plus one cycle per counter restart) after the falling start edge at the pin.

Reset
REQ-026 While rst=1 at a clock edge: state=IDLE, counters=0, shift register=0, rx_data=0x00, rx_avail=0, rx_error=0, rx_overrun=0, rx_busy=0, synchronizer flops=1.
REQ-027 rst asserted mid-frame SHALL abort the frame with no output update; reception resumes only at the next falling edge after rst=0.

Verification (clk_freq=100000000, baud_rate=625000 -> divisor 10, 160 clk per bit)
REQ-028 Send 0xA5 with 1 stop bit -> rx_data=0xA5, rx_avail=1, rx_error=0 about 2+1520 cycles after the start edge; rx_ack -> rx_avail=0 on the next cycle.
REQ-029 Send 0x3C with stop bit forced to 0 -> rx_error=1, rx_avail=0, rx_data keeps its old value; the line held low afterwards starts no new frame.
REQ-030 Low pulse of 40 clk on an idle line -> returns to IDLE after the mid-start sample; rx_avail=0 and rx_error=0.
REQ-031 Send 0x11 then 0x22 with no ack -> rx_data=0x22, rx_avail=1, rx_overrun=1; rx_ack clears both flags.
REQ-032 Assert rst halfway through the data bits of 0xFF -> all outputs 0 and rx_busy=0; a following 0x5A is received correctly.
REQ-033 Pulse rx_ack exactly on the completion cycle of 0x77 -> rx_avail stays 1, rx_data=0x77, rx_overrun=0.
